// File: rtl/traffic_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_multi
// Purpose  : Parametrised N-direction traffic light controller with run-time
//            green/yellow/all-red durations, a tick time base, an actuated
//            (demand-skipping) mode and emergency pre-emption.
// Ports    : clock, reset      - clock / synchronous active-high reset
//            tick              - 1-cycle time-base strobe
//            green_time        - green duration in ticks (0 treated as 1)
//            yellow_time       - yellow duration in ticks (0 treated as 1)
//            allred_time       - all-red clearance in ticks (0 = one clock)
//            actuated          - 0 fixed round robin, 1 demand-actuated
//            demand            - per-direction vehicle request (level)
//            emerg_req         - emergency pre-emption request (level)
//            emerg_dir         - direction granted to the emergency vehicle
//            lights            - per direction {red,yellow,green}
//            active_dir        - direction currently green or yellow
//            phase             - 00 ALL_RED, 01 GREEN, 10 YELLOW, 11 EMERG
// Revision : 1.0 - initial release
// ============================================================================
module traffic_ctrl_multi #(
  parameter  int NUM_DIR = 4,
  parameter  int CNT_W   = 8,
  localparam int DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [CNT_W-1:0]       green_time,
  input  logic [CNT_W-1:0]       yellow_time,
  input  logic [CNT_W-1:0]       allred_time,
  input  logic                   actuated,
  input  logic [NUM_DIR-1:0]     demand,
  input  logic                   emerg_req,
  input  logic [DIR_W-1:0]       emerg_dir,
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase
);

  localparam logic [1:0] c_ALL_RED = 2'b00;
  localparam logic [1:0] c_GREEN   = 2'b01;
  localparam logic [1:0] c_YELLOW  = 2'b10;
  localparam logic [1:0] c_EMERG   = 2'b11;

  logic [1:0]           r_phase;
  logic [DIR_W-1:0]     r_dir;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_time;   // duration sampled at phase entry
  logic                 r_first;  // no green served yet since reset
  logic [3*NUM_DIR-1:0] r_lights;

  logic [1:0]           w_phase_nxt;
  logic [DIR_W-1:0]     w_dir_nxt;
  logic                 w_first_nxt;
  logic                 w_enter;
  logic                 w_hold;
  logic                 w_expired;
  logic                 w_ar_done;
  logic                 w_other_dem;
  logic [DIR_W-1:0]     w_next_dir;
  logic [CNT_W-1:0]     w_time_nxt;
  logic [3*NUM_DIR-1:0] w_lights_nxt;
  logic [NUM_DIR-1:0]   w_self;

  // Compare in CNT_W+1 bits so cnt+1 never wraps.
  assign w_expired = tick &&
    (({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, r_time});

  // allred_time of 0 stays in ALL_RED for exactly one clock, tick or not.
  assign w_ar_done = (r_time == '0) || w_expired;

  assign w_self      = {{(NUM_DIR-1){1'b0}}, 1'b1} << r_dir;
  assign w_other_dem = |(demand & ~w_self);

  // Next direction to serve after the current one: in actuated mode the first
  // requesting direction after r_dir (wrapping round to r_dir itself last).
  always_comb begin : p_next_dir
    logic [DIR_W-1:0] v_idx;
    logic             v_found;
    v_idx      = '0;
    v_found    = 1'b0;
    w_next_dir = DIR_W'((int'(r_dir) + 1) % NUM_DIR);
    if (actuated) begin
      for (int k = 1; k <= NUM_DIR; k++) begin
        v_idx = DIR_W'((int'(r_dir) + k) % NUM_DIR);
        if (!v_found && demand[v_idx]) begin
          w_next_dir = v_idx;
          v_found    = 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin : p_next_state
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_first_nxt = r_first;
    w_enter     = 1'b0;
    w_hold      = 1'b0;
    case (r_phase)
      c_ALL_RED: begin
        if (w_ar_done) begin
          w_enter     = 1'b1;
          w_first_nxt = 1'b0;
          if (emerg_req) begin
            w_phase_nxt = c_EMERG;
            w_dir_nxt   = emerg_dir;
          end else begin
            w_phase_nxt = c_GREEN;
            w_dir_nxt   = r_first ? '0 : w_next_dir;
          end
        end
      end
      c_GREEN: begin
        if (emerg_req) begin
          // Already green for the emergency direction: no yellow needed.
          w_enter     = 1'b1;
          w_phase_nxt = (emerg_dir == r_dir) ? c_EMERG : c_YELLOW;
        end else if (w_expired) begin
          if (actuated && !w_other_dem) begin
            w_hold = 1'b1;  // green extension, re-checked every tick
          end else begin
            w_enter     = 1'b1;
            w_phase_nxt = c_YELLOW;
          end
        end
      end
      c_YELLOW: begin
        if (w_expired) begin
          w_enter     = 1'b1;
          w_phase_nxt = c_ALL_RED;
        end
      end
      c_EMERG: begin
        if (!emerg_req) begin
          w_enter     = 1'b1;
          w_phase_nxt = c_YELLOW;
        end
      end
    endcase
  end

  // Duration for the phase being entered.
  always_comb begin : p_time_sel
    w_time_nxt = '0;
    case (w_phase_nxt)
      c_GREEN:   w_time_nxt = (green_time  == '0) ? CNT_W'(1) : green_time;
      c_YELLOW:  w_time_nxt = (yellow_time == '0) ? CNT_W'(1) : yellow_time;
      c_ALL_RED: w_time_nxt = allred_time;
      c_EMERG:   w_time_nxt = '0;
    endcase
  end

  // Output logic: lamps decoded from the next state so they register
  // alongside it.
  always_comb begin : p_output
    w_lights_nxt = {NUM_DIR{3'b100}};
    if (w_phase_nxt != c_ALL_RED) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if (w_dir_nxt == DIR_W'(i)) begin
          w_lights_nxt[3*i +: 3] = (w_phase_nxt == c_YELLOW) ? 3'b010 : 3'b001;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin : p_state
    if (reset) begin
      r_phase  <= c_ALL_RED;
      r_dir    <= '0;
      r_cnt    <= '0;
      r_time   <= allred_time;
      r_first  <= 1'b1;
      r_lights <= {NUM_DIR{3'b100}};
    end else begin
      r_phase  <= w_phase_nxt;
      r_dir    <= w_dir_nxt;
      r_first  <= w_first_nxt;
      r_lights <= w_lights_nxt;
      if (w_enter) begin
        r_cnt  <= '0;
        r_time <= w_time_nxt;
      end else if (tick && !w_hold && (r_phase != c_EMERG)) begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign lights     = r_lights;
  assign active_dir = r_dir;
  assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_ctrl_multi
// Purpose  : Self-checking bench for traffic_ctrl_multi (NUM_DIR=4). A
//            behavioural model counts down remaining ticks per phase and
//            predicts phase, active direction and lamps every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_ctrl_multi;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          tick;
  logic [7:0]    green_time, yellow_time, allred_time;
  logic          actuated;
  logic [N-1:0]  demand;
  logic          emerg_req;
  logic [1:0]    emerg_dir;
  logic [3*N-1:0] lights;
  logic [1:0]    active_dir;
  logic [1:0]    phase;

  int checks = 0;
  int errors = 0;

  // model state: phase 0 AR, 1 G, 2 Y, 3 E
  int m_ph, m_dir, m_rem;
  bit m_first;
  logic [3*N-1:0] prev_lights;
  bit prev_valid;

  traffic_ctrl_multi #(.NUM_DIR(N), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .green_time(green_time), .yellow_time(yellow_time), .allred_time(allred_time),
    .actuated(actuated), .demand(demand), .emerg_req(emerg_req), .emerg_dir(emerg_dir),
    .lights(lights), .active_dir(active_dir), .phase(phase)
  );

  always #5 clock = ~clock;

  function automatic logic [3*N-1:0] exp_lights(int ph, int dir);
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++) begin
      l[3*i +: 3] = 3'b100;
      if (ph != 0 && i == dir) l[3*i +: 3] = (ph == 2) ? 3'b010 : 3'b001;
    end
    return l;
  endfunction

  task automatic enter(int ph);
    m_ph = ph;
    case (ph)
      0: m_rem = int'(allred_time);
      1: m_rem = (green_time == 0) ? 1 : int'(green_time);
      2: m_rem = (yellow_time == 0) ? 1 : int'(yellow_time);
      default: m_rem = 0;
    endcase
  endtask

  function automatic int pick_next();
    if (m_first) return 0;
    if (actuated) begin
      for (int k = 1; k <= N; k++)
        if (demand[(m_dir + k) % N]) return (m_dir + k) % N;
    end
    return (m_dir + 1) % N;
  endfunction

  // Advance the model by one clock using the inputs now on the pins.
  task automatic model_step();
    if (reset) begin
      m_dir = 0; m_first = 1; enter(0);
      return;
    end
    case (m_ph)
      0: begin
        if (m_rem == 0 || (tick && m_rem <= 1)) begin
          if (emerg_req) m_dir = int'(emerg_dir);
          else m_dir = pick_next();
          m_first = 0;
          enter(emerg_req ? 3 : 1);
        end else if (tick) m_rem--;
      end
      1: begin
        if (emerg_req) enter((int'(emerg_dir) == m_dir) ? 3 : 2);
        else if (tick) begin
          if (m_rem <= 1) begin
            if (!(actuated && ((demand & ~(4'b0001 << m_dir)) == 0))) enter(2);
          end else m_rem--;
        end
      end
      2: begin
        if (tick) begin
          if (m_rem <= 1) enter(0);
          else m_rem--;
        end
      end
      default: if (!emerg_req) enter(2);
    endcase
  endtask

  task automatic check(bit was_reset);
    int nonred;
    logic [3*N-1:0] el;
    el = exp_lights(m_ph, m_dir);
    checks++;
    assert (phase === 2'(m_ph)) else begin
      errors++; $error("FAIL phase: observed %0d expected %0d at %0t", phase, m_ph, $time);
    end
    checks++;
    assert (active_dir === 2'(m_dir)) else begin
      errors++; $error("FAIL active_dir: observed %0d expected %0d at %0t", active_dir, m_dir, $time);
    end
    checks++;
    assert (lights === el) else begin
      errors++; $error("FAIL lights: observed %b expected %b at %0t", lights, el, $time);
    end
    nonred = 0;
    for (int i = 0; i < N; i++) if (lights[3*i +: 3] !== 3'b100) nonred++;
    checks++;
    assert (nonred <= 1) else begin
      errors++; $error("FAIL one_nonred: observed %0d expected <=1 at %0t", nonred, $time);
    end
    if (prev_valid && !was_reset) begin
      for (int i = 0; i < N; i++) begin
        if (prev_lights[3*i +: 3] == 3'b001) begin
          checks++;
          assert (lights[3*i +: 3] !== 3'b100) else begin
            errors++; $error("FAIL grn_to_red dir%0d: observed %b expected not 100 at %0t",
                             i, lights[3*i +: 3], $time);
          end
        end
      end
    end
    prev_lights = lights;
    prev_valid  = 1'b1;
  endtask

  task automatic cycle();
    bit r;
    r = reset;
    model_step();
    @(posedge clock);
    #1;
    check(r);
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); cycle();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; tick = 1'b1; actuated = 1'b0; demand = '0;
    emerg_req = 1'b0; emerg_dir = '0;
    green_time = 8'd3; yellow_time = 8'd1; allred_time = 8'd1;
    m_ph = 0; m_dir = 0; m_rem = 0; m_first = 1; prev_valid = 0; prev_lights = '0;

    // 1: fixed round robin, tick every cycle
    do_reset();
    repeat (24) cycle();

    // 2: tick every 4th clock, green 2 ticks; timing changes mid-phase
    do_reset();
    green_time = 8'd2;
    for (int i = 0; i < 48; i++) begin
      tick = ((i % 4) == 3);
      if (i == 20) begin green_time = 8'd5; yellow_time = 8'd0; end
      cycle();
    end
    tick = 1'b1; green_time = 8'd3; yellow_time = 8'd1;

    // 3: actuated mode, green extension and demand skipping
    do_reset();
    actuated = 1'b1;
    repeat (8) cycle();
    demand = 4'b1000;
    repeat (10) cycle();
    demand = 4'b0000;
    repeat (10) cycle();
    actuated = 1'b0;

    // 4: emergency for dir2 during dir0 green
    do_reset();
    repeat (2) cycle();
    emerg_req = 1'b1; emerg_dir = 2'd2;
    repeat (8) cycle();
    emerg_req = 1'b0;
    repeat (8) cycle();

    // 5: emergency for the direction already green
    do_reset();
    repeat (2) cycle();
    emerg_req = 1'b1; emerg_dir = 2'd0;
    repeat (4) cycle();
    emerg_req = 1'b0;
    repeat (6) cycle();

    // 6: reset while yellow; allred 0 passes in one clock
    allred_time = 8'd0; yellow_time = 8'd3; green_time = 8'd2;
    do_reset();
    guard = 0;
    while (m_ph != 2 && guard < 50) begin cycle(); guard++; end
    checks++;
    assert (guard < 50) else begin
      errors++; $error("FAIL reach_yellow: observed timeout expected yellow at %0t", $time);
    end
    cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    repeat (6) cycle();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 2) != 0);
      green_time  = 8'($urandom_range(0, 3));
      yellow_time = 8'($urandom_range(0, 3));
      allred_time = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) actuated = ~actuated;
      if ($urandom_range(0, 7) == 0) demand = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) emerg_req = ~emerg_req;
      if ($urandom_range(0, 9) == 0) emerg_dir = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
